// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the core-MMIO to UART register-port bridge.
// Holds the FSM state encoding, UART register offsets and byte replication.
package uart_bridge_pkg;

  localparam int BUS_XLEN = 64;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    RDW  = 3'd3,
    RESP = 3'd4
  } state_t;

  // 16550-style register offsets inside the 8-byte window.
  localparam logic [7:0] RBR_THR = 8'd0;
  localparam logic [7:0] IER     = 8'd1;
  localparam logic [7:0] IIR_FCR = 8'd2;
  localparam logic [7:0] LCR     = 8'd3;
  localparam logic [7:0] MCR     = 8'd4;
  localparam logic [7:0] LSR     = 8'd5;
  localparam logic [7:0] MSR     = 8'd6;
  localparam logic [7:0] SCR     = 8'd7;

  function automatic logic [BUS_XLEN-1:0] replicate8(input logic [7:0] b);
    return {(BUS_XLEN/8){b}};
  endfunction

endpackage

// File: rtl/uart_mmio_bridge.sv
// Bridges one core-side valid/ready MMIO request at a time onto the 8-bit UART
// register port, issuing a single strobe per hit, and registers the UART irq.
module uart_mmio_bridge
  import uart_bridge_pkg::*;
#(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] BASE_ADDR = XLEN'(64'h1000_0000),
  parameter int              WIN_BYTES = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wen,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            uart_wen,
  output logic [7:0]      uart_waddr,
  output logic [7:0]      uart_wdata,
  output logic            uart_ren,
  output logic [7:0]      uart_raddr,
  input  logic [7:0]      uart_rdata,
  input  logic            uart_irq,
  output logic            irq_out,
  output logic [2:0]      dbg_state
);

  // Handshake semantics: a request transfers on a rising clk edge where
  // req_valid & req_ready; a response transfers where resp_valid & resp_ready.
  // Neither valid may depend combinationally on its ready.

  if (XLEN != BUS_XLEN || BASE_ADDR[2:0] != 3'b000) begin : g_param_check
    $error("uart_mmio_bridge: XLEN must be 64 and BASE_ADDR 8-byte aligned");
  end

  state_t            r_state;
  state_t            w_next;
  logic [XLEN-1:0]   r_rdata;
  logic              r_err;
  logic [7:0]        r_waddr;
  logic [7:0]        r_wdata;
  logic [7:0]        r_raddr;
  logic              r_irq;

  logic [XLEN-1:0]   w_off;
  logic              w_hit;
  logic [2:0]        w_lane;
  logic [7:0]        w_byte;
  logic              w_accept;

  // Offset wraps in XLEN bits, so addresses below BASE_ADDR become huge and miss.
  assign w_off    = req_addr - BASE_ADDR;
  assign w_hit    = (w_off < XLEN'(WIN_BYTES));
  assign w_lane   = req_addr[2:0];
  assign w_byte   = req_wdata[{w_lane, 3'b000} +: 8];
  assign w_accept = req_valid && (r_state == IDLE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (!w_hit)       w_next = RESP;
          else if (req_wen) w_next = WR;
          else              w_next = RD;
        end
      end
      WR:   w_next = RESP;
      RD:   w_next = RDW;
      RDW:  w_next = RESP;
      RESP: begin
        if (resp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_irq   <= uart_irq;
    end
  end

  // UART address/data registers only move on an accepted hit, so they hold
  // their last value while the strobes are low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_waddr <= 8'd0;
      r_wdata <= 8'd0;
      r_raddr <= 8'd0;
    end else begin
      if (w_accept) begin
        r_err   <= !w_hit;
        r_rdata <= '0;
        if (w_hit && req_wen) begin
          r_waddr <= w_off[7:0];
          r_wdata <= w_byte;
        end
        if (w_hit && !req_wen) begin
          r_raddr <= w_off[7:0];
        end
      end
      if (r_state == RDW) begin
        r_rdata <= XLEN'(replicate8(uart_rdata));
      end
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign uart_wen   = (r_state == WR);
  assign uart_ren   = (r_state == RD);
  assign uart_waddr = r_waddr;
  assign uart_wdata = r_wdata;
  assign uart_raddr = r_raddr;
  assign irq_out    = r_irq;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Randomized scoreboard bench for uart_mmio_bridge: a driver issues requests and
// queues expected responses/strobes; independent monitors pop and compare.
module tb_uart_mmio_bridge;

  localparam logic [63:0] BASE = 64'h1000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_wen;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;
  logic        uart_wen, uart_ren;
  logic [7:0]  uart_waddr, uart_wdata, uart_raddr, uart_rdata;
  logic        uart_irq, irq_out;
  logic [2:0]  dbg_state;

  uart_mmio_bridge dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .uart_wen(uart_wen), .uart_waddr(uart_waddr), .uart_wdata(uart_wdata),
    .uart_ren(uart_ren), .uart_raddr(uart_raddr), .uart_rdata(uart_rdata),
    .uart_irq(uart_irq), .irq_out(irq_out), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / bookkeeping ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_evt(input string name);
    n_chk++;
    $display("FAIL %s: event not expected / not seen (t=%0t)", name, $time);
  endtask

  // ---------------- scoreboard state ----------------
  // exp_q entry: {err[96], rdata[95:32], first_valid_cycle[31:0]}
  logic [96:0] exp_q[$];
  // strb_q entry: {is_write[48], addr[47:40], data[39:32], strobe_cycle[31:0]}
  logic [48:0] strb_q[$];
  logic [7:0]  model_mem[8];
  logic [7:0]  last_w_off, last_w_byte;
  int          strobe_cnt = 0;
  int          resp_cnt   = 0;

  // ---------------- UART register-port slave ----------------
  logic [7:0] uart_mem[8];
  logic       rd_pend = 1'b0;
  logic [7:0] rd_addr = 8'd0;

  always @(posedge clk) begin
    #1;
    if (rd_pend) begin
      uart_rdata = uart_mem[rd_addr[2:0]];
      rd_pend    = 1'b0;
    end else begin
      uart_rdata = 8'($urandom);
    end
  end

  // ---------------- response back-pressure driver ----------------
  int rr_mode = 2;  // 0 = hold low, 1 = random, 2 = hold high
  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       resp_ready = 1'b0;
      1:       resp_ready = ($urandom_range(0, 3) != 0);
      default: resp_ready = 1'b1;
    endcase
  end

  // ---------------- strobe monitor ----------------
  always @(negedge clk) begin
    if (reset_n && (uart_wen || uart_ren)) begin
      logic [48:0] s;
      check("strobe_exclusive", 64'(uart_wen & uart_ren), 64'd0);
      strobe_cnt++;
      if (uart_wen) uart_mem[uart_waddr[2:0]] = uart_wdata;
      else begin
        rd_pend = 1'b1;
        rd_addr = uart_raddr;
      end
      if (strb_q.size() == 0) fail_evt("unexpected_strobe");
      else begin
        s = strb_q.pop_front();
        check("strobe_kind", 64'(uart_wen), 64'(s[48]));
        check("strobe_cycle", 64'(cyc), 64'(s[31:0]));
        if (uart_wen) begin
          check("uart_waddr", 64'(uart_waddr), 64'(s[47:40]));
          check("uart_wdata", 64'(uart_wdata), 64'(s[39:32]));
        end else begin
          check("uart_raddr", 64'(uart_raddr), 64'(s[47:40]));
        end
      end
    end
  end

  // ---------------- response monitor ----------------
  int first_valid = -1;
  always @(negedge clk) begin
    if (!reset_n) first_valid = -1;
    else if (resp_valid) begin
      logic [96:0] e;
      check("req_ready_in_resp", 64'(req_ready), 64'd0);
      if (first_valid < 0) first_valid = cyc;
      if (exp_q.size() == 0) fail_evt("unexpected_resp");
      else begin
        e = exp_q[0];
        check("resp_err", 64'(resp_err), 64'(e[96]));
        check("resp_rdata", resp_rdata, e[95:32]);
        if (resp_ready) begin
          check("resp_latency", 64'(first_valid), 64'(e[31:0]));
          void'(exp_q.pop_front());
          resp_cnt++;
          first_valid = -1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic wen, input logic [63:0] addr, input logic [63:0] wdata);
    logic [63:0] off;
    logic [7:0]  b;
    int          n;
    int          t_acc;
    @(posedge clk); #1;
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!req_ready) begin
      fail_evt("req_accept_timeout");
      req_valid = 1'b0;
      return;
    end
    t_acc = cyc + 1;
    off = addr - BASE;
    b   = 8'((wdata >> (8 * (addr % 8))) & 64'hFF);
    if (!(off < 64'd8)) begin
      exp_q.push_back({1'b1, 64'd0, 32'(t_acc)});
    end else if (wen) begin
      model_mem[off[2:0]] = b;
      last_w_off  = off[7:0];
      last_w_byte = b;
      strb_q.push_back({1'b1, off[7:0], b, 32'(t_acc)});
      exp_q.push_back({1'b0, 64'd0, 32'(t_acc + 1)});
    end else begin
      strb_q.push_back({1'b0, off[7:0], 8'd0, 32'(t_acc)});
      exp_q.push_back({1'b0, 64'(model_mem[off[2:0]]) * 64'h0101_0101_0101_0101, 32'(t_acc + 2)});
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wen   = 1'($urandom);
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      fail_evt("drain_timeout");
      exp_q.delete();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int sc0, rc0;
    logic [63:0] a;
    for (int i = 0; i < 8; i++) begin
      model_mem[i] = 8'(i * 17 + 3);
      uart_mem[i]  = 8'(i * 17 + 3);
    end
    reset_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0;
    req_addr = '0; req_wdata = '0; uart_irq = 1'b0;
    resp_ready = 1'b1; uart_rdata = 8'd0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    check("rst_strobes", 64'({uart_wen, uart_ren}), 64'd0);
    check("rst_uart_regs", 64'({uart_waddr, uart_wdata, uart_raddr}), 64'd0);
    check("rst_irq_out", 64'(irq_out), 64'd0);
    @(posedge clk); #3 reset_n = 1'b1;

    // directed: write hit, lane select, read hit, misses with wrap
    issue(1'b1, BASE + 0, 64'h41);
    issue(1'b1, BASE + 3, 64'h0000_0000_8300_0000);
    issue(1'b1, BASE + 5, 64'h0000_6000_0000_0000);
    issue(1'b0, BASE + 5, {$urandom, $urandom});
    drain();
    check("hold_uart_waddr", 64'(uart_waddr), 64'(last_w_off));
    check("hold_uart_wdata", 64'(uart_wdata), 64'(last_w_byte));
    sc0 = strobe_cnt;
    issue(1'b0, BASE + 8, 64'd0);
    issue(1'b0, BASE - 1, 64'd0);
    issue(1'b1, 64'd0, 64'hFFFF);
    drain();
    check("miss_no_strobe", 64'(strobe_cnt), 64'(sc0));

    // back-pressure: response stalls, a second request waits
    rr_mode = 0;
    sc0 = strobe_cnt;
    issue(1'b1, BASE + 7, {$urandom, $urandom});
    req_valid = 1'b1; req_wen = 1'b0; req_addr = BASE + 1;
    repeat (10) begin
      @(negedge clk);
      check("bp_req_ready", 64'(req_ready), 64'd0);
    end
    check("bp_resp_valid", 64'(resp_valid), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rr_mode = 2;
    drain();
    check("bp_one_strobe", 64'(strobe_cnt), 64'(sc0 + 1));

    // async reset while the read sits in its data-capture cycle
    issue(1'b0, BASE + 2, 64'd0);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check("arst_resp_valid", 64'(resp_valid), 64'd0);
    check("arst_req_ready", 64'(req_ready), 64'd1);
    check("arst_uart_ren", 64'(uart_ren), 64'd0);
    exp_q.delete();
    strb_q.delete();
    sc0 = strobe_cnt;
    rc0 = resp_cnt;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("arst_no_replay_strobe", 64'(strobe_cnt), 64'(sc0));
    check("arst_no_replay_resp", 64'(resp_cnt), 64'(rc0));
    check("arst_idle_ready", 64'(req_ready), 64'd1);

    // irq register: one-cycle level latency
    @(posedge clk); #1 uart_irq = 1'b1;
    @(negedge clk);
    check("irq_before_edge", 64'(irq_out), 64'd0);
    @(negedge clk);
    check("irq_after_edge", 64'(irq_out), 64'd1);
    for (int i = 0; i < 8; i++) begin
      logic v;
      v = 1'($urandom);
      @(posedge clk); #1 uart_irq = v;
      @(posedge clk);
      @(negedge clk);
      check("irq_level", 64'(irq_out), 64'(v));
    end

    // randomized traffic with random back-pressure
    rr_mode = 1;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 9))
        0:       a = BASE + 64'(8 + $urandom_range(0, 100));
        1:       a = BASE - 64'(1 + $urandom_range(0, 100));
        2:       a = {$urandom, $urandom};
        default: a = BASE + 64'($urandom_range(0, 7));
      endcase
      issue(1'($urandom), a, {$urandom, $urandom});
    end
    drain();
    rr_mode = 2;
    repeat (5) @(negedge clk);
    check("end_strobe_q_empty", 64'(strb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (%0d/%0d so far)", n_pass, n_chk);
    $fatal(1);
  end

endmodule

// File: doc/uart_mmio_bridge.md
Name: uart_mmio_bridge

Overview:
- Register-bus initiator that drives the 8-bit UART register port (wen/waddr/wdata, ren/raddr/rdata, irq) on behalf of the core's MMIO path.
- Accepts one valid/ready request at a time from the core-side MMIO crossbar and decodes it against an 8-byte UART window.
- Issues exactly one single-cycle UART write or read pulse per request, then returns a valid/ready response with byte-lane-aligned data.
- Also registers the UART interrupt toward the interrupt controller.

Parameters:
- XLEN, 64, data width of the core-side request/response.
- BASE_ADDR, 64'h1000_0000, byte address of UART register 0; must be 8-byte aligned.
- WIN_BYTES, 8, size of the decoded UART register window.

Ports:
- clk  in  1  core clock; all state on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  bridge can accept a request.
- req_wen  in  1  1 = write, 0 = read.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  write data; the byte lane is selected by req_addr[2:0].
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  XLEN  read byte replicated into all 8 lanes; 0 for writes.
- resp_err  out  1  address was outside the window.
- uart_wen  out  1  single-cycle write strobe.
- uart_waddr  out  8  register offset.
- uart_wdata  out  8  write byte.
- uart_ren  out  1  single-cycle read strobe.
- uart_raddr  out  8  register offset.
- uart_rdata  in  8  read byte; valid the cycle after the uart_ren cycle.
- uart_irq  in  1  UART interrupt level.
- irq_out  out  1  registered uart_irq.

Behaviour:
- Reset values: state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; uart_wen=0; uart_ren=0; uart_waddr=0; uart_wdata=0; uart_raddr=0; irq_out=0.
- Address decode: off = req_addr - BASE_ADDR, computed in XLEN bits with wrap.
  - Hit when off < WIN_BYTES.
  - Register offset = off[7:0].
  - Lane = req_addr[2:0].
- States: IDLE, WR, RD, RDW, RESP.
- req_ready is 1 only in IDLE.
- A handshake (req_valid & req_ready) captures wen, offset, lane byte and hit. The next state is:
  - miss: RESP with resp_err=1, resp_rdata=0, no UART strobe.
  - hit write: WR.
  - hit read: RD.
- WR: uart_wen=1 for exactly this cycle with uart_waddr/uart_wdata. Next state RESP with resp_err=0, resp_rdata=0.
- RD: uart_ren=1 for exactly this cycle with uart_raddr. Next state RDW.
- RDW: capture uart_rdata into all 8 bytes of resp_rdata. Next state RESP.
- RESP: resp_valid=1; resp_rdata and resp_err are held stable until resp_ready=1, then IDLE.
  - The next request cannot be accepted in the same cycle as the response handshake; accept at earliest the following cycle.
- Latency with the request accepted at edge T:
  - Write: uart_wen during cycle T+1; resp_valid from T+2.
  - Read: uart_ren during T+1; data captured at the end of T+2; resp_valid from T+3.
  - Miss: resp_valid from T+1.
- Strobes are never asserted outside WR/RD. uart_wen and uart_ren are never high together.
- uart_waddr, uart_wdata and uart_raddr hold their last value when the strobes are low.
- irq_out <= uart_irq every cycle: 1-cycle latency, level (not edge).
- Reset asserted mid-transaction: immediate return to reset values. No strobe completes partially, the in-flight response is dropped, and no replay happens after reset release.
- Back-pressure: resp_ready held low indefinitely keeps the block in RESP and no new UART access occurs.

Decomposition:
- Shared package uart_bridge_pkg holds:
  - state enum {IDLE, WR, RD, RDW, RESP}.
  - UART register offset constants RBR_THR=0, IER=1, IIR_FCR=2, LCR=3, MCR=4, LSR=5, MSR=6, SCR=7.
  - Function replicate8(byte) -> XLEN.
- No sub-module: decode, FSM and irq register live in one module.

Test Plan:
- Write hit: req addr=BASE+0, wdata=64'h41, wen=1 -> uart_wen=1 one cycle at T+1 with waddr=0, wdata=8'h41; resp_valid at T+2, resp_err=0, resp_rdata=0.
- Lane select: write addr=BASE+3, wdata=64'h0000_0000_8300_0000 -> uart_waddr=3, uart_wdata=8'h83.
- Read hit: read addr=BASE+5 with uart_rdata=8'h60 in the cycle after ren -> uart_ren at T+1, raddr=5; resp_valid at T+3, resp_rdata=64'h6060_6060_6060_6060.
- Miss and wrap: reads at BASE+8 and BASE-1 -> no strobe; resp_valid at T+1, resp_err=1, resp_rdata=0.
- Back-pressure: hold resp_ready=0 for 10 cycles with req_valid=1 -> req_ready=0 throughout, resp_rdata stable, exactly one uart strobe total.
- Async reset mid-read: drop reset_n during RDW -> immediately resp_valid=0, req_ready=1 after release, no extra uart_ren; uart_irq toggled 0->1 -> irq_out=1 one cycle later.
